// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   state_t      : sequencer state (RUN, MEM_WAIT)
//   DEF_TIMEOUT  : default MEM_WAIT cycles before mem_timeout is raised
//   DEF_CNT_W    : default performance counter width
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   en    : count this cycle
//   count : current value, holds at all-ones instead of wrapping
module pipe_hazard_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core. Arbitrates memory stall
// over branch flush over data hazard, remembers branches that resolve during
// a memory stall, flags over-long memory waits and keeps perf counters.
//   clk, rst      : clock (rising edge) and async active-high reset
//   hazard        : data hazard from the hazard detection unit
//   branch_taken  : one-cycle pulse, branch resolved taken in EXE
//   mem_req       : MEM stage holds a load/store
//   mem_ready     : SRAM access completes this cycle
//   freeze_if     : hold PC and IF stage register
//   flush_if      : clear IF stage register
//   bubble_id     : clear ID/EXE register (insert NOP)
//   freeze_all    : hold every pipeline register and the PC
//   mem_timeout   : sticky, a memory wait reached TIMEOUT cycles
//   stall_cycles  : saturating count of frozen cycles
//   flush_events  : saturating count of flush_if cycles
//
// state    | meaning
// RUN      | pipeline flowing, no outstanding multi-cycle access
// MEM_WAIT | waiting on the SRAM controller, pipeline frozen until ready
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             bubble_id,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic           stall_raw;
  logic           flush_eff;
  logic           branch_pending;
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_req && !mem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             state_nxt = RUN;
      default:                             state_nxt = RUN;
    endcase
  end

  // Mealy stall: an access that completes in its first cycle never freezes.
  assign stall_raw = (state == RUN) ? (mem_req && !mem_ready) : !mem_ready;
  assign flush_eff = (branch_taken || branch_pending) && !stall_raw;

  always_comb begin
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    bubble_id  = 1'b0;
    freeze_all = 1'b0;
    if (!rst) begin
      if (stall_raw) begin
        freeze_all = 1'b1;
        freeze_if  = 1'b1;
      end else begin
        flush_if  = flush_eff;
        bubble_id = flush_eff || hazard;
        // The flush discards the hazard-causing instruction, so no freeze.
        freeze_if = hazard && !flush_eff;
      end
    end
  end

  // A branch seen while frozen is replayed as a flush on the first free cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            branch_pending <= 1'b0;
    else if (stall_raw && branch_taken) branch_pending <= 1'b1;
    else if (!stall_raw)                branch_pending <= 1'b0;
  end

  // Wait counter holds at TIMEOUT-1 so a very long wait cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
      else                       wait_cnt    <= wait_cnt + 1'b1;
    end
  end

  pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (freeze_all || freeze_if),
    .count (stall_cycles)
  );

  pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_if),
    .count (flush_events)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Drives the freeze/flush controls of the IF stage register and PC, the bubble insert into the ID/EXE register, and a global freeze for multi-cycle SRAM accesses in MEM.
- Arbitrates between three competing causes: memory stall over branch flush over data hazard.
- Adds sequential tracking for branches deferred by a stall, a memory-wait timeout, and saturating performance counters.

Parameters:
- TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is raised.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- hazard  input  1  data-hazard request from the hazard detection unit (combinational, current cycle).
- branch_taken  input  1  one-cycle pulse from the EXE stage: branch resolved taken.
- mem_req  input  1  MEM stage holds a load/store this cycle.
- mem_ready  input  1  SRAM controller: access completes this cycle.
- freeze_if  output  1  hold PC and the IF stage register.
- flush_if  output  1  clear the IF stage register (pc and instruction forced to 0).
- bubble_id  output  1  clear the ID/EXE register (insert NOP).
- freeze_all  output  1  hold every pipeline register and the PC.
- mem_timeout  output  1  sticky: a memory wait reached TIMEOUT.
- stall_cycles  output  CNT_W  saturating count of frozen cycles.
- flush_events  output  CNT_W  saturating count of flush_if cycles.

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
  - RUN to MEM_WAIT when mem_req=1 and mem_ready=0.
  - MEM_WAIT to RUN when mem_ready=1.
  - mem_req is don't-care while in MEM_WAIT.
- freeze_all (Mealy) = (RUN and mem_req and not mem_ready) or (MEM_WAIT and not mem_ready).
  - A single-cycle access with mem_ready=1 in the same cycle causes no freeze.
- branch_pending register:
  - Set when branch_taken=1 and freeze_all=1.
  - Cleared on the first cycle with freeze_all=0.
- flush_eff = (branch_taken or branch_pending) and not freeze_all.
- Output priority:
  - freeze_all=1: freeze_if=1, flush_if=0, bubble_id=0.
  - Otherwise: flush_if=flush_eff; bubble_id=flush_eff or hazard; freeze_if=hazard and not flush_eff. A branch discards the hazard-causing instruction, so no freeze.
- flush_if is asserted for exactly one cycle per taken branch, including a deferred one. A branch during a stall is never lost or duplicated.
- Wait counter (width clog2(TIMEOUT)+1):
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle with mem_ready=0.
  - When it reaches TIMEOUT-1 with mem_ready=0, mem_timeout is set. mem_timeout stays set until rst.
  - The FSM keeps waiting after a timeout; no abort.
- stall_cycles increments on each cycle with freeze_all or freeze_if. flush_events increments on each cycle with flush_if. Both saturate at 2^CNT_W-1 with no wrap.
- Counters and mem_timeout are registered; they update on the rising edge after the qualifying cycle.
- Reset:
  - While rst=1, force freeze_if, flush_if, bubble_id and freeze_all to 0.
  - Clear state to RUN; clear branch_pending, the wait counter, mem_timeout, stall_cycles and flush_events to 0.
  - rst mid-MEM_WAIT returns to RUN and drops any pending branch.

Decomposition:
- Shared package:
  - FSM state enum (RUN=0, MEM_WAIT=1).
  - Default TIMEOUT and CNT_W constants.
- One natural sub-module: sat_counter (enable, CNT_W, saturating, async reset). Instantiated twice for the performance counters.

Test Plan:
- Reset: rst=1 with hazard=1 and mem_req=1 -> all four control outputs 0; counters 0; mem_timeout 0; state RUN.
- Hazard only: hazard=1 for 2 cycles -> freeze_if=1 and bubble_id=1 both cycles, flush_if=0; stall_cycles=2.
- Branch plus hazard in the same cycle -> flush_if=1, bubble_id=1, freeze_if=0; flush_events=1.
- Memory stall: mem_req=1, mem_ready=0 for 3 cycles, then ready -> freeze_all=1 for 3 cycles and 0 on the ready cycle; stall_cycles=3.
- Deferred branch: branch_taken pulse in stall cycle 2 of 3 -> no flush during the stall; flush_if=1 for exactly 1 cycle on the ready cycle; flush_events=1.
- Timeout: TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th wait cycle; it stays 1 after mem_ready and returning to RUN until rst.
